// File: rtl/upsample_8x_zero_stuff.sv
// Rate-restore front end: expands each accepted low-rate sample into a burst of
// G_RATE high-rate samples, either gain-compensated zero-stuffed or held.
module upsample_8x_zero_stuff #(
  parameter int G_DWIDTH     = 24,
  parameter int G_RATE       = 8,
  parameter int G_GAIN_SHIFT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                hold_mode,
  input  logic [G_DWIDTH-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [G_DWIDTH-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                dout_first
);

  // state  | meaning
  // S_IDLE | no burst in flight, din_ready follows enable
  // S_BUSY | emitting burst phases 0..G_RATE-1 on dout

  localparam int PW = (G_RATE > 1) ? $clog2(G_RATE) : 1;
  localparam int EW = G_DWIDTH + G_GAIN_SHIFT;
  localparam logic [PW-1:0]       LAST_PH = PW'(G_RATE - 1);
  localparam logic [G_DWIDTH-1:0] MAX_POS = {1'b0, {(G_DWIDTH-1){1'b1}}};
  localparam logic [G_DWIDTH-1:0] MAX_NEG = {1'b1, {(G_DWIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [G_DWIDTH-1:0] samp_q, samp_d;
  logic [G_DWIDTH-1:0] dout_q, dout_d;
  logic                mode_q, mode_d;
  logic                first_q, first_d;

  logic [EW-1:0]       din_shl;
  logic [G_DWIDTH-1:0] din_sat;
  logic                last_ph;
  logic                load;
  logic                advance;

  // The extension is exactly as wide as the shift, so din_shl holds the exact
  // product; overflow shows up as the upper G_GAIN_SHIFT+1 bits disagreeing.
  always_comb begin
    din_shl = {{G_GAIN_SHIFT{din[G_DWIDTH-1]}}, din} << G_GAIN_SHIFT;
    if (din_shl[EW-1:G_DWIDTH-1] == {(G_GAIN_SHIFT+1){din_shl[EW-1]}})
      din_sat = din_shl[G_DWIDTH-1:0];
    else if (din_shl[EW-1])
      din_sat = MAX_NEG;
    else
      din_sat = MAX_POS;
  end

  assign last_ph   = (phase_q == LAST_PH);
  assign din_ready = enable && ((state_q == S_IDLE) || (last_ph && dout_ready));
  assign load      = din_valid && din_ready;
  assign advance   = (state_q == S_BUSY) && dout_ready;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    samp_d  = samp_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    first_d = first_q;
    if (!enable) begin
      state_d = S_IDLE;
      phase_d = '0;
      samp_d  = '0;
      mode_d  = 1'b0;
      dout_d  = '0;
      first_d = 1'b0;
    end else if (load) begin
      state_d = S_BUSY;
      phase_d = '0;
      samp_d  = din;
      mode_d  = hold_mode;
      dout_d  = hold_mode ? din : din_sat;
      first_d = 1'b1;
    end else if (advance) begin
      first_d = 1'b0;
      if (last_ph) begin
        state_d = S_IDLE;
        phase_d = '0;
        dout_d  = '0;
      end else begin
        phase_d = phase_q + 1'b1;
        dout_d  = mode_q ? samp_q : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      samp_q  <= '0;
      mode_q  <= 1'b0;
      dout_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      samp_q  <= samp_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      first_q <= first_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == S_BUSY);
  assign dout_first = first_q;

endmodule
